// File: rtl/margin_argmin_scan_if.sv
// Sample-in / result-out bundle for margin_argmin_scan; slave is the scan stage,
// master is whoever feeds samples and consumes the result.
interface margin_argmin_scan_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 16,
  parameter int MAX_SAMPLES = 512
);
  localparam int CW = $clog2(MAX_SAMPLES) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_top1;
  logic [DATA_WIDTH-1:0] in_top2;
  logic [IDX_WIDTH-1:0]  in_idx;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic [DATA_WIDTH-1:0] out_margin;
  logic [CW-1:0]         out_count;

  modport slave (
    input  in_valid, in_top1, in_top2, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_idx, out_margin, out_count
  );

  modport master (
    output in_valid, in_top1, in_top2, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_idx, out_margin, out_count
  );
endinterface

// File: rtl/margin_argmin_scan.sv
// Per-frame argmin of |top1-top2|; result valid 2 cycles after the last sample is accepted.
// Input is stalled (in_ready=0) outside SCAN; the result is held in DONE until out_ready.
module margin_argmin_scan #(
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 16,
  parameter int MAX_SAMPLES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  margin_argmin_scan_if.slave   bus
);
  localparam int CW = $clog2(MAX_SAMPLES) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_m_q, s1_m_d;
  logic [IDX_WIDTH-1:0]  s1_idx_q, s1_idx_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s2_last_q, s2_last_d;
  logic                  seen_q, seen_d;
  logic [DATA_WIDTH-1:0] min_margin_q, min_margin_d;
  logic [IDX_WIDTH-1:0]  min_idx_q, min_idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  accept;

  assign accept = bus.in_valid && (state_q == SCAN);

  always_comb begin
    state_d      = state_q;
    s1_vld_d     = accept;
    s1_m_d       = s1_m_q;
    s1_idx_d     = s1_idx_q;
    s1_last_d    = s1_last_q;
    s2_last_d    = s1_vld_q && s1_last_q;
    seen_d       = seen_q;
    min_margin_d = min_margin_q;
    min_idx_d    = min_idx_q;
    count_d      = count_q;

    if (accept) begin
      s1_m_d    = (bus.in_top1 >= bus.in_top2) ? bus.in_top1 - bus.in_top2
                                               : bus.in_top2 - bus.in_top1;
      s1_idx_d  = bus.in_idx;
      s1_last_d = bus.in_last;
    end

    // Strict compare keeps the earliest sample on ties; the first sample always loads.
    if (s1_vld_q) begin
      if (!seen_q || (s1_m_q < min_margin_q)) begin
        min_margin_d = s1_m_q;
        min_idx_d    = s1_idx_q;
      end
      seen_d = 1'b1;
      if (count_q != CW'(MAX_SAMPLES)) count_d = count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          seen_d       = 1'b0;
          min_margin_d = '0;
          min_idx_d    = '0;
          count_d      = '0;
        end
      end
      SCAN:    if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   if (s2_last_q)             state_d = DONE;
      DONE:    if (bus.out_ready)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_vld_q     <= 1'b0;
      s1_m_q       <= '0;
      s1_idx_q     <= '0;
      s1_last_q    <= 1'b0;
      s2_last_q    <= 1'b0;
      seen_q       <= 1'b0;
      min_margin_q <= '0;
      min_idx_q    <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      s1_vld_q     <= s1_vld_d;
      s1_m_q       <= s1_m_d;
      s1_idx_q     <= s1_idx_d;
      s1_last_q    <= s1_last_d;
      s2_last_q    <= s2_last_d;
      seen_q       <= seen_d;
      min_margin_q <= min_margin_d;
      min_idx_q    <= min_idx_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready   = (state_q == SCAN);
  assign bus.out_valid  = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign bus.out_idx    = min_idx_q;
  assign bus.out_margin = min_margin_q;
  assign bus.out_count  = count_q;
endmodule

// File: tb/tb_margin_argmin_scan.sv
// Directed bench for margin_argmin_scan: hand-computed frames, ties, extremes,
// result backpressure, a 512-sample frame with bubbles, and reset mid-frame.
module tb_margin_argmin_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  margin_argmin_scan_if #(.DATA_WIDTH(16), .IDX_WIDTH(16), .MAX_SAMPLES(512)) bus ();

  margin_argmin_scan #(.DATA_WIDTH(16), .IDX_WIDTH(16), .MAX_SAMPLES(512)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("idle_after_consume_valid", {31'd0, bus.out_valid}, 32'd0);
    check("idle_after_consume_busy", {31'd0, busy}, 32'd0);
  endtask

  // One sample, accepted at the next edge; on the last sample the exact result latency is checked.
  task automatic send(input logic [15:0] t1, input logic [15:0] t2,
                      input logic [15:0] idx, input logic last);
    bus.in_valid = 1'b1;
    bus.in_top1  = t1;
    bus.in_top2  = t2;
    bus.in_idx   = idx;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (last) begin
      check("lat_t0_valid", {31'd0, bus.out_valid}, 32'd0);
      check("drain_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("lat_t1_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
      check("lat_t2_valid", {31'd0, bus.out_valid}, 32'd1);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] idx,
                              input logic [15:0] margin, input logic [9:0] count);
    check({tag, "_idx"}, {16'd0, bus.out_idx}, {16'd0, idx});
    check({tag, "_margin"}, {16'd0, bus.out_margin}, {16'd0, margin});
    check({tag, "_count"}, {22'd0, bus.out_count}, {22'd0, count});
  endtask

  initial begin
    logic [15:0] m;
    bus.in_valid  = 1'b0;
    bus.in_top1   = '0;
    bus.in_top2   = '0;
    bus.in_idx    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_result("rst", 16'd0, 16'd0, 10'd0);

    // Basic frame: margins 60,5,20,190.
    start_frame();
    check("scan_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("scan_busy", {31'd0, busy}, 32'd1);
    send(16'd100, 16'd40, 16'd0, 1'b0);
    send(16'd90,  16'd85, 16'd1, 1'b0);
    send(16'd50,  16'd70, 16'd2, 1'b0);
    send(16'd200, 16'd10, 16'd3, 1'b1);
    check_result("basic", 16'd1, 16'd5, 10'd4);
    consume();

    // Ties: margins 7,3,3,9 -> earliest of the two 3s.
    start_frame();
    send(16'd10, 16'd3,  16'd10, 1'b0);
    send(16'd3,  16'd6,  16'd11, 1'b0);
    send(16'd20, 16'd17, 16'd12, 1'b0);
    send(16'd0,  16'd9,  16'd13, 1'b1);
    check_result("tie", 16'd11, 16'd3, 10'd4);
    consume();

    // Single sample with maximal margin.
    start_frame();
    send(16'hFFFF, 16'h0000, 16'd5, 1'b1);
    check_result("single_max", 16'd5, 16'hFFFF, 10'd1);
    consume();

    // Zero margin, then hold the result under backpressure with a stray start.
    start_frame();
    send(16'h1234, 16'h1234, 16'd9, 1'b1);
    check_result("zero", 16'd9, 16'd0, 10'd1);
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_result("bp", 16'd9, 16'd0, 10'd1);
    end
    start = 1'b0;
    consume();
    check_result("held_after_consume", 16'd9, 16'd0, 10'd1);

    // 512 samples with random bubbles; unique minimum margin 1 at idx 317.
    start_frame();
    for (int i = 0; i < 512; i++) begin
      int bubbles;
      bubbles = $urandom_range(0, 2);
      for (int b = 0; b < bubbles; b++) tick();
      m = (i == 317) ? 16'd1 : 16'(2 + (i % 50));
      if (i % 2 == 1) send(16'd500, 16'd500 + m, 16'(i), (i == 511));
      else            send(16'd500 + m, 16'd500, 16'(i), (i == 511));
    end
    check_result("long", 16'd317, 16'd1, 10'd512);
    consume();

    // Reset mid-frame after 20 samples, one of them with margin 0.
    start_frame();
    for (int i = 0; i < 20; i++) begin
      if (i == 3) send(16'd77, 16'd77, 16'(i), 1'b0);
      else        send(16'd300, 16'd100, 16'(i), 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check_result("abort", 16'd0, 16'd0, 10'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // start together with rst: reset wins.
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("rst_beats_start", {31'd0, busy}, 32'd0);

    // Fresh frame with non-monotonic indices: margins 10,2,5.
    start_frame();
    send(16'd30, 16'd20, 16'd7, 1'b0);
    send(16'd10, 16'd12, 16'd2, 1'b0);
    send(16'd40, 16'd35, 16'd8, 1'b1);
    check_result("fresh", 16'd2, 16'd2, 10'd3);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
